serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//   Bit-serial add sequencer around a single 1-bit full-adder cell
//   (S = A^B^CI, CO = A&B | (A^B)&CI).
//   Latches two WIDTH-bit operands on a start request and feeds the cell one
//   bit per clock, LSB first. A carry flop holds CI between bits.
//   Reports the WIDTH-bit sum plus carry-out with a busy/done handshake.
//   Area-minimal alternative to a ripple chain, for slow datapaths.
// PARAMETERS
//   WIDTH   4   operand/sum width in bits; legal range 2..32
// PORTS
//   clk      in   1      system clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      request; sampled only in IDLE
//   a        in   WIDTH  operand A; captured when start is accepted
//   b        in   WIDTH  operand B; captured when start is accepted
//   cin      in   1      initial carry-in; captured when start is accepted
//   busy     out  1      high while in RUN or DONE
//   done     out  1      one-cycle pulse; sum/cout valid
//   sum      out  WIDTH  result, registered; held until next accepted start
//   cout     out  1      final carry-out, registered; held likewise
// BEHAVIOUR
//   - Reset is asynchronous, active-low, effective immediately at any time:
//     state=IDLE, busy=0, done=0, sum=0, cout=0, carry flop=0, bit count=0,
//     operand shift regs=0.
//   - Reset mid-operation abandons the operation. No done is produced.
//   - FSM states:
//     IDLE: on start=1, load a->A_sr, b->B_sr, cin->carry; clear count and sum;
//           go to RUN.
//     RUN:  each edge: cell inputs are A_sr[0], B_sr[0], carry.
//           S shifts into sum at the MSB (sum >> 1, sum[WIDTH-1]=S).
//           carry<=CO. A_sr and B_sr shift right. count++.
//           When count==WIDTH-1 at the edge, go to DONE and cout<=CO.
//     DONE: done=1 for exactly one cycle, then IDLE.
//   - Latency: start sampled at edge k. done is high in the cycle following
//     edge k+WIDTH+1. Operation-to-operation throughput is WIDTH+2 cycles.
//   - start while busy (RUN or DONE) is ignored, not queued.
//     Operands and cin may change freely after acceptance.
//   - busy rises on the edge that accepts start and falls on the edge
//     leaving DONE.
//   - sum and cout are stable only outside RUN. Consumers sample on done.
//   - Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
//     All operands are unsigned.
//   - The count register is $clog2(WIDTH) bits wide and never wraps past
//     WIDTH-1.
// CONFIGURATION
//   SERIAL_SUB_EN defined:
//     - Adds input port `sub` (1 bit), sampled with start.
//     - sub=1: ~b is loaded into B_sr and carry is forced to 1 (cin ignored),
//       giving a - b. cout=1 means no borrow.
//     - sub=0: identical to plain add.
//   SERIAL_SUB_EN undefined:
//     - No sub port. Add only.
// TESTING  (WIDTH=4)
//   1. a=5,b=3,cin=0,start pulse -> done at start edge+5 cycles;
//      sum=8, cout=0; busy high 5 cycles.
//   2. a=15,b=1,cin=0 -> sum=0, cout=1. Then a=7,b=8,cin=1 -> sum=0, cout=1.
//   3. start re-asserted with a=1,b=1 during RUN and during DONE -> ignored;
//      first result unchanged; one done pulse only.
//   4. rst_n low for 1 cycle at RUN bit 2 -> all outputs 0 at once, IDLE,
//      no done. A fresh a=2,b=2 start then gives sum=4.
//   5. Back-to-back: start held high continuously -> new op accepted in the
//      cycle after DONE; done pulses every 6 cycles.
//   6. SERIAL_SUB_EN: a=5,b=3,sub=1 -> sum=2, cout=1.
//      a=3,b=5,sub=1 -> sum=14, cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add sequencer around one full-adder cell.
// Ports: clk, rst_n, start, a, b, cin [, sub] -> busy, done, sum, cout.
// Optional: define SERIAL_SUB_EN to add the sub port (a - b mode).
module serial_adder_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  always_comb begin
    fa_s  = a_sr[0] ^ b_sr[0] ^ carry;
    fa_co = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & carry);
  end

  // Subtract = a + ~b + 1; cout then reads as "no borrow".
  always_comb begin
    b_load = b;
    c_load = cin;
`ifdef SERIAL_SUB_EN
    if (sub) begin
      b_load = ~b;
      c_load = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      count <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= c_load;
            count <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_co;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          if (count == LAST) begin
            cout  <= fa_co;
            state <= S_DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed vectors for serial_adder_ctrl, WIDTH=4.
// Define SERIAL_SUB_EN to also exercise the subtract mode.
module tb_serial_adder_ctrl;

  localparam int W = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic         sub_r = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic         cout;
  logic [W-1:0] sum;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_SUB_EN
    .sub   (sub_r),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] ta,
                        input logic [W-1:0] tb_,
                        input logic         tc,
                        input bit           poke,
                        input logic [W-1:0] es,
                        input logic         ec);
    int cyc;
    int nb;
    int nd;
    a = ta;
    b = tb_;
    cin = tc;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = ~ta;
    b = ~tb_;
    cin = ~tc;
    check("busy_rise", busy, 1);
    nb = 1;
    cyc = 0;
    while (cyc < 20) begin
      tick();
      cyc++;
      if (busy) nb++;
      if (done) break;
      if (poke && cyc <= 4) begin
        start = 1'b1;
        a = 1;
        b = 1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("latency", cyc, 5);
    check("busy_cycles", nb, 5);
    check("sum", sum, es);
    check("cout", cout, ec);
    check("busy_fall", busy, 0);
    nd = 0;
    nb = 0;
    repeat (7) begin
      tick();
      if (done) nd++;
      if (busy) nb++;
    end
    check("no_extra_done", nd, 0);
    check("idle_busy", nb, 0);
    check("sum_hold", sum, es);
    check("cout_hold", cout, ec);
  endtask

  initial begin
    int nd;
    int idx;
    int last;
    logic [W-1:0] exp_s [3];
    logic         exp_c [3];
    logic [W-1:0] nxt_a [3];
    logic [W-1:0] nxt_b [3];

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;
    tick();

    run_op(4'd5, 4'd3, 1'b0, 1'b0, 4'd8, 1'b0);
    run_op(4'd15, 4'd1, 1'b0, 1'b0, 4'd0, 1'b1);
    run_op(4'd6, 4'd7, 1'b0, 1'b1, 4'd13, 1'b0);
    run_op(4'd7, 4'd8, 1'b1, 1'b0, 4'd0, 1'b1);

    a = 4'd3;
    b = 4'd3;
    cin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_busy", busy, 1);
    check("mid_sum", sum, 8);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sum", sum, 0);
    check("arst_cout", cout, 0);
    tick();
    rst_n = 1'b1;
    nd = 0;
    repeat (10) begin
      tick();
      if (done || busy) nd++;
    end
    check("post_rst_quiet", nd, 0);
    run_op(4'd2, 4'd2, 1'b0, 1'b0, 4'd4, 1'b0);

    exp_s = '{4'd8, 4'd2, 4'd14};
    exp_c = '{1'b0, 1'b1, 1'b1};
    nxt_a = '{4'd9, 4'd15, 4'd0};
    nxt_b = '{4'd9, 4'd15, 4'd0};
    a = 4'd5;
    b = 4'd3;
    cin = 1'b0;
    start = 1'b1;
    idx = 0;
    last = 0;
    for (int t = 1; t <= 30 && idx < 3; t++) begin
      tick();
      if (done) begin
        check("b2b_sum", sum, exp_s[idx]);
        check("b2b_cout", cout, exp_c[idx]);
        if (idx == 0) check("b2b_first", t, 6);
        else check("b2b_period", t - last, 6);
        last = t;
        a = nxt_a[idx];
        b = nxt_b[idx];
        idx++;
        if (idx == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", idx, 3);
    repeat (8) tick();

`ifdef SERIAL_SUB_EN
    sub_r = 1'b1;
    run_op(4'd5, 4'd3, 1'b0, 1'b0, 4'd2, 1'b1);
    run_op(4'd3, 4'd5, 1'b1, 1'b0, 4'd14, 1'b0);
    sub_r = 1'b0;
    run_op(4'd5, 4'd3, 1'b1, 1'b0, 4'd9, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
